apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Shares the single APB master-bridge command port (transfer/read_write/addr/data) among
//  NREQ local requesters. Round-robin arbitration; one transfer in flight at a time.
//  Holds command fields stable until the bridge reports completion; captures read data.
//  Returns a per-requester done/err pulse. Sits between requesters and the two-slave APB bridge top.
// PARAMETERS
//  NREQ     2      number of requesters (2..8)
//  AW       `AW    address width (from define.svh)
//  DW       `DW    data width (from define.svh)
//  TIMEOUT  64     max cycles in WAIT before forced abort (>=4)
// PORTS
//  pclk               in   1         clock, all logic on posedge
//  presetn            in   1         async active-low reset
//  req                in   NREQ      request; requester holds high until its done pulse
//  req_rw             in   NREQ      per-requester direction, 1=write 0=read
//  req_addr           in   NREQ*AW   per-requester address, slice i = [i*AW +: AW]
//  req_wdata          in   NREQ*DW   per-requester write data, slice i = [i*DW +: DW]
//  gnt                out  NREQ      one-hot, high for whole owned transfer
//  done               out  NREQ      one-cycle completion pulse to owner
//  err                out  1         valid with done; 1 = timeout abort
//  rdata              out  DW        captured read data, valid with done on reads, held after
//  transfer           out  1         bridge transfer request
//  read_write         out  1         bridge direction, 1=write
//  apb_write_paddr    out  AW        bridge write address
//  apb_write_data     out  DW        bridge write data
//  apb_read_paddr     out  AW        bridge read address
//  apb_read_data_out  in   DW        bridge read data
//  xfer_done          in   1         bridge completion pulse (PENABLE&&PREADY cycle)
// BEHAVIOUR
//  Reset (async, presetn=0): all outputs 0; FSM=IDLE; rr pointer=0; timeout counter=0.
//  FSM IDLE -> CMD -> WAIT -> RESP -> IDLE.
//   IDLE: any req sampled high -> pick winner; gnt/transfer/fields registered, valid next cycle.
//   CMD (1 cycle): transfer=1, fields driven from winner slice, latched (not live-tracked).
//   WAIT: transfer=1, fields stable; xfer_done=1 -> RESP; counter==TIMEOUT-1 -> RESP, err.
//   RESP (1 cycle): transfer=0, done[owner]=1, gnt cleared; rdata <= apb_read_data_out
//    sampled on the xfer_done cycle for reads; rdata unchanged for writes/timeouts.
//  Latency: req high at edge k -> transfer high at k+1; xfer_done at edge m -> done at m+1.
//  transfer low >=2 cycles (RESP + IDLE) between transfers; bridge always returns to IDLE.
//  Address muxing: write -> apb_write_paddr=addr, apb_read_paddr holds last value.
//   Read -> apb_read_paddr=addr, apb_write_paddr/apb_write_data hold last value.
//  Arbitration: round-robin; search starts at ptr; after grant to i, ptr <= (i+1) mod NREQ.
//   Simultaneous reqs: lowest index at/after ptr wins; losers wait, no starvation (<= NREQ-1 turns).
//  Boundary rules:
//   owner drops req mid-transfer: ignored, transfer completes, done still pulses.
//   xfer_done in IDLE/CMD/RESP: ignored.
//   xfer_done coincident with timeout terminal count: normal completion, err=0.
//   req for new transfer during RESP: not sampled until IDLE.
//   reset mid-transfer: immediate return to reset values; no done pulse issued.
//  Timeout counter: clears on CMD entry, increments each WAIT cycle, saturating width clog2(TIMEOUT).
// STRUCTURE
//  Package apb_arb_pkg: state enum (IDLE, CMD, WAIT, RESP); RW_WRITE=1/RW_READ=0; default widths.
//  Sub-module apb_rr_picker: combinational req+ptr -> one-hot winner + any_req.
//  Top holds FSM, ptr, latched command, timeout counter, rdata register.
// TESTING
//  1 reset: presetn=0 mid-WAIT -> transfer=0, gnt=0, done=0 same cycle; ptr=0 after release.
//  2 single write: req[0], rw=1, addr=0x0A5, wdata=0x3C -> transfer at k+1.
//    apb_write_paddr=0x0A5, data=0x3C held; xfer_done at k+3 -> done[0] at k+4, err=0.
//  3 single read: req[1], rw=0, addr=0x105; read_data_out=0x5A at xfer_done -> rdata=0x5A.
//    done[1]=1 on the same cycle.
//  4 contention: req[0],req[1] together from reset -> grants 0 then 1 then 0.
//    transfer low >=2 cycles between grants.
//  5 timeout: no xfer_done for 64 WAIT cycles -> done=1, err=1, rdata unchanged, FSM to IDLE.
//  6 corner: owner drops req in WAIT -> done still pulses.
//    xfer_done forced in IDLE -> no done, no state change.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> CMD -> WAIT -> RESP -> IDLE)
//   RW_WRITE / RW_READ : encoding of the per-requester direction bit
//   DEF_* : default parameter values used by the arbiter and its picker
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_AW      = 9;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index where the search starts
//   winner  : one-hot, first requester at or after ptr (wrapping)
//   any_req : at least one request is active
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = |req;
        for (int off = 0; off < NREQ; off++) begin
            // ptr is always < NREQ, so one subtraction is enough to wrap
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if ((winner == '0) && req[idx]) begin
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master-bridge command port among NREQ requesters with
// round-robin arbitration and one transfer in flight at a time.
// Ports:
//   pclk, presetn        : clock, async active-low reset
//   req/req_rw           : per-requester request and direction (1=write)
//   req_addr/req_wdata   : per-requester address / write data, packed slices
//   gnt                  : one-hot owner, high for the whole owned transfer
//   done/err             : one-cycle completion pulse to owner; err=timeout
//   rdata                : captured read data, held between reads
//   transfer, read_write : bridge command
//   apb_write_paddr/apb_write_data/apb_read_paddr : bridge command fields
//   apb_read_data_out    : bridge read data
//   xfer_done            : bridge completion pulse
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_rw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic [DW-1:0]    rdata,
    output logic             transfer,
    output logic             read_write,
    output logic [AW-1:0]    apb_write_paddr,
    output logic [DW-1:0]    apb_write_data,
    output logic [AW-1:0]    apb_read_paddr,
    input  logic [DW-1:0]    apb_read_data_out,
    input  logic             xfer_done
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   tcnt;
    logic [NREQ-1:0]    win_oh;
    logic               any_req;
    logic               win_rw;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_wdata;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               grant_take;
    logic               finish;

    apb_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr),
        .winner  (win_oh),
        .any_req (any_req)
    );

    // Select the winner's command fields from the packed request buses
    always_comb begin
        win_rw    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_rw    = req_rw[i];
                win_addr  = req_addr[i*AW +: AW];
                win_wdata = req_wdata[i*DW +: DW];
                win_idx   = PTR_W'(i);
            end
        end
        ptr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Requests are only sampled in IDLE, so a request raised during RESP
    // waits one more cycle; xfer_done only matters in WAIT.
    assign grant_take = (state == IDLE) && any_req;
    assign finish     = (state == WAIT) && (xfer_done || (tcnt == TERM));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CMD;
            CMD:     state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ptr             <= '0;
            tcnt            <= '0;
            gnt             <= '0;
            done            <= '0;
            err             <= 1'b0;
            rdata           <= '0;
            transfer        <= 1'b0;
            read_write      <= 1'b0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;

            if (grant_take) begin
                gnt        <= win_oh;
                transfer   <= 1'b1;
                read_write <= win_rw;
                ptr        <= ptr_nxt;
                tcnt       <= '0;
                // Only the field used by this direction moves; the other
                // bridge address keeps its last value.
                if (win_rw == RW_WRITE) begin
                    apb_write_paddr <= win_addr;
                    apb_write_data  <= win_wdata;
                end else begin
                    apb_read_paddr <= win_addr;
                end
            end

            if (state == WAIT) begin
                tcnt <= sat_inc(tcnt);
            end

            if (finish) begin
                done     <= gnt;
                // A completion on the terminal-count cycle is still a success
                err      <= ~xfer_done;
                gnt      <= '0;
                transfer <= 1'b0;
                if (xfer_done && (read_write == RW_READ)) begin
                    rdata <= apb_read_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int TO   = 64;

    logic             pclk;
    logic             presetn;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  req_rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             err;
    logic [DW-1:0]    rdata;
    logic             transfer;
    logic             read_write;
    logic [AW-1:0]    apb_write_paddr;
    logic [DW-1:0]    apb_write_data;
    logic [AW-1:0]    apb_read_paddr;
    logic [DW-1:0]    apb_read_data_out;
    logic             xfer_done;

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .req               (req),
        .req_rw            (req_rw),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .gnt               (gnt),
        .done              (done),
        .err               (err),
        .rdata             (rdata),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .xfer_done         (xfer_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] oh;
        logic            err;
        logic [DW-1:0]   rdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl_rdata;

    task automatic push_exp(input logic [NREQ-1:0] oh, input logic e, input logic is_read,
                            input logic [DW-1:0] rd);
        exp_t x;
        if (is_read && !e) mdl_rdata = rd;
        x.oh    = oh;
        x.err   = e;
        x.rdata = mdl_rdata;
        sb.push_back(x);
    endtask

    // Scoreboard monitor and inter-transfer gap check
    int   low_run = 0;
    logic seen_tr = 1'b0;
    always @(negedge pclk) begin
        if (!presetn) begin
            low_run = 0;
            seen_tr = 1'b0;
        end else begin
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("done_owner", 32'(done), 32'(e.oh));
                    check_val("done_err", 32'(err), 32'(e.err));
                    check_val("done_rdata", 32'(rdata), 32'(e.rdata));
                end
            end
            if (transfer) begin
                if (seen_tr && low_run > 0) check_val("xfer_gap_ge2", 32'(low_run >= 2), 32'd1);
                seen_tr = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rw[i]            = rw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
    endtask

    task automatic wait_transfer();
        int n;
        n = 0;
        while (!transfer && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check_val("xfer_start", 32'(transfer), 32'd1);
    endtask

    // Plays the bridge: waits for a command, checks it, completes it after dly cycles
    task automatic bridge_serve(input int dly, input logic [DW-1:0] rd, input logic [NREQ-1:0] exp_oh,
                                input logic exp_rw, input logic [AW-1:0] exp_addr,
                                input logic [DW-1:0] exp_wd, input logic [NREQ-1:0] drop_wait,
                                input logic [NREQ-1:0] drop_done);
        wait_transfer();
        check_val("gnt", 32'(gnt), 32'(exp_oh));
        check_val("read_write", 32'(read_write), 32'(exp_rw));
        if (exp_rw) begin
            check_val("wr_paddr", 32'(apb_write_paddr), 32'(exp_addr));
            check_val("wr_data", 32'(apb_write_data), 32'(exp_wd));
        end else begin
            check_val("rd_paddr", 32'(apb_read_paddr), 32'(exp_addr));
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge pclk);
            if (i == 0) req = req & ~drop_wait;
        end
        check_val("no_early_done", 32'(done), 32'd0);
        check_val("hold_transfer", 32'(transfer), 32'd1);
        check_val("hold_addr", 32'(exp_rw ? apb_write_paddr : apb_read_paddr), 32'(exp_addr));
        xfer_done         = 1'b1;
        apb_read_data_out = rd;
        @(negedge pclk);
        xfer_done = 1'b0;
        check_val("done_latency", 32'(done), 32'(exp_oh));
        check_val("gnt_cleared", 32'(gnt), 32'd0);
        req = req & ~drop_done;
        @(negedge pclk);
        check_val("done_pulse_end", 32'(done), 32'd0);
        check_val("xfer_low_after", 32'(transfer), 32'd0);
    endtask

    initial begin
        int n;
        presetn           = 1'b0;
        req               = '0;
        req_rw            = '0;
        req_addr          = '0;
        req_wdata         = '0;
        apb_read_data_out = '0;
        xfer_done         = 1'b0;
        mdl_rdata         = '0;

        repeat (2) @(negedge pclk);
        check_val("rst_transfer", 32'(transfer), 32'd0);
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        check_val("rst_wpaddr", 32'(apb_write_paddr), 32'd0);
        check_val("rst_rpaddr", 32'(apb_read_paddr), 32'd0);
        presetn = 1'b1;
        @(negedge pclk);

        // Reset in the middle of WAIT after granting requester 0
        set_req(0, 1'b1, 9'h011, 8'h22);
        wait_transfer();
        repeat (2) @(negedge pclk);
        check_val("pre_rst_transfer", 32'(transfer), 32'd1);
        presetn = 1'b0;
        #1;
        check_val("midrst_transfer", 32'(transfer), 32'd0);
        check_val("midrst_gnt", 32'(gnt), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        req = '0;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Contention from reset: expected grant order 0, 1, 0
        set_req(0, 1'b1, 9'h0A5, 8'h3C);
        set_req(1, 1'b0, 9'h105, 8'h00);
        push_exp(2'b01, 1'b0, 1'b0, 8'h00);
        push_exp(2'b10, 1'b0, 1'b1, 8'h5A);
        push_exp(2'b01, 1'b0, 1'b0, 8'h00);
        bridge_serve(2, 8'h77, 2'b01, 1'b1, 9'h0A5, 8'h3C, 2'b00, 2'b00);
        bridge_serve(2, 8'h5A, 2'b10, 1'b0, 9'h105, 8'h00, 2'b00, 2'b00);
        bridge_serve(2, 8'h77, 2'b01, 1'b1, 9'h0A5, 8'h3C, 2'b00, 2'b11);
        repeat (3) @(negedge pclk);
        check_val("idle_after_drop", 32'(transfer), 32'd0);

        // Single write with latency check: transfer visible the cycle after the sampling edge
        set_req(0, 1'b1, 9'h0A5, 8'h3C);
        check_val("w_transfer_before", 32'(transfer), 32'd0);
        push_exp(2'b01, 1'b0, 1'b0, 8'h00);
        @(negedge pclk);
        check_val("w_transfer_k1", 32'(transfer), 32'd1);
        bridge_serve(1, 8'hEE, 2'b01, 1'b1, 9'h0A5, 8'h3C, 2'b00, 2'b01);
        @(negedge pclk);

        // Single read from requester 1; write fields must hold
        set_req(1, 1'b0, 9'h105, 8'h00);
        push_exp(2'b10, 1'b0, 1'b1, 8'hA6);
        bridge_serve(2, 8'hA6, 2'b10, 1'b0, 9'h105, 8'h00, 2'b00, 2'b10);
        check_val("rd_hold_wpaddr", 32'(apb_write_paddr), 32'h0A5);
        check_val("rd_hold_wdata", 32'(apb_write_data), 32'h3C);
        check_val("rd_rdata_held", 32'(rdata), 32'hA6);
        @(negedge pclk);

        // Timeout: 1 CMD cycle + TO WAIT cycles, then done with err
        set_req(0, 1'b0, 9'h1F0, 8'h00);
        push_exp(2'b01, 1'b1, 1'b1, 8'h99);
        wait_transfer();
        check_val("to_rpaddr", 32'(apb_read_paddr), 32'h1F0);
        check_val("to_wpaddr_held", 32'(apb_write_paddr), 32'h0A5);
        apb_read_data_out = 8'h99;
        n = 0;
        while (done == '0 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check_val("to_cycles", 32'(n), 32'(TO + 1));
        check_val("to_err", 32'(err), 32'd1);
        req = '0;
        @(negedge pclk);
        check_val("to_done_end", 32'(done), 32'd0);
        check_val("to_rdata_kept", 32'(rdata), 32'hA6);
        @(negedge pclk);

        // xfer_done on the terminal-count cycle counts as a normal completion
        set_req(1, 1'b0, 9'h033, 8'h00);
        push_exp(2'b10, 1'b0, 1'b1, 8'hC3);
        bridge_serve(TO, 8'hC3, 2'b10, 1'b0, 9'h033, 8'h00, 2'b00, 2'b10);
        @(negedge pclk);

        // Owner drops its request during WAIT: done still pulses
        set_req(0, 1'b1, 9'h0F0, 8'h5E);
        push_exp(2'b01, 1'b0, 1'b0, 8'h00);
        bridge_serve(3, 8'h00, 2'b01, 1'b1, 9'h0F0, 8'h5E, 2'b01, 2'b01);
        check_val("drop_req_low", 32'(req), 32'd0);
        @(negedge pclk);

        // xfer_done while IDLE is ignored
        xfer_done = 1'b1;
        repeat (3) @(negedge pclk);
        xfer_done = 1'b0;
        @(negedge pclk);
        check_val("idle_xd_done", 32'(done), 32'd0);
        check_val("idle_xd_transfer", 32'(transfer), 32'd0);
        check_val("idle_xd_gnt", 32'(gnt), 32'd0);
        check_val("idle_xd_rdata", 32'(rdata), 32'hC3);

        repeat (2) @(negedge pclk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
